data_access_controller: RTL and testbench



---
 rtl/riscv_mem_pkg.sv | 46 ++++
 rtl/load_align_extend.sv | 29 ++
 rtl/data_access_controller.sv | 118 +++++++++++
 tb/tb_data_access_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage data path: RV32I load/store width codes,
// the access controller state encoding and the request legality rule.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } dac_state_t;

    // A request is legal only when exactly one of read/write is set, the width
    // code exists for that direction, and the address is naturally aligned.
    function automatic logic access_legal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (rd && !wr) begin
            case (f3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = !off[0];
                F3_LW:         ok = (off == 2'b00);
                default:       ok = 1'b0;
            endcase
        end else if (wr && !rd) begin
            case (f3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = !off[0];
                F3_SW:   ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Picks the addressed byte/half out of a cache word and sign- or zero-extends it
// according to the load width code.
module load_align_extend
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        case (func3)
            F3_LB:   result = 32'(byte_s);
            F3_LH:   result = 32'(half_s);
            F3_LBU:  result = {24'h000000, shifted[7:0]};
            F3_LHU:  result = {16'h0000, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/data_access_controller.sv
// MEM-stage sequencer: validates a load/store, holds a word-aligned cache request
// through the cache busy-wait handshake, stalls the pipeline and registers load data.
module data_access_controller
    import riscv_mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        busy_wait,
    output logic        access_fault,
    output logic        dcache_read,
    output logic        dcache_write,
    output logic [31:0] dcache_address,
    output logic [31:0] dcache_writedata,
    output logic [3:0]  dcache_byteen,
    input  logic [31:0] dcache_readdata,
    input  logic        dcache_busywait
);

    dac_state_t  state;
    logic [2:0]  func3_q;
    logic [1:0]  offset_q;
    logic        req;
    logic        legal;
    logic [3:0]  st_byteen;
    logic [31:0] st_data;
    logic [31:0] ld_result;

    assign req   = mem_read | mem_write;
    assign legal = access_legal(mem_read, mem_write, func3, address[1:0]);

    // The stall must be visible in the same cycle the request appears, so these
    // two are decoded from state rather than registered.
    assign busy_wait    = ((state == IDLE) && req && legal) || (state == ACCESS);
    assign access_fault = (state == IDLE) && req && !legal;

    always_comb begin
        st_byteen = 4'b0000;
        st_data   = write_data;
        case (func3)
            F3_SB: begin
                st_byteen = 4'b0001 << address[1:0];
                st_data   = {4{write_data[7:0]}};
            end
            F3_SH: begin
                st_byteen = 4'b0011 << {address[1], 1'b0};
                st_data   = {2{write_data[15:0]}};
            end
            F3_SW: begin
                st_byteen = 4'b1111;
                st_data   = write_data;
            end
            default: begin
                st_byteen = 4'b0000;
                st_data   = write_data;
            end
        endcase
        if (!mem_write) begin
            st_byteen = 4'b0000;
        end
    end

    load_align_extend u_load_align_extend (
        .func3  (func3_q),
        .offset (offset_q),
        .word   (dcache_readdata),
        .result (ld_result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            func3_q          <= 3'b000;
            offset_q         <= 2'b00;
            load_data        <= 32'h0;
            dcache_read      <= 1'b0;
            dcache_write     <= 1'b0;
            dcache_address   <= 32'h0;
            dcache_writedata <= 32'h0;
            dcache_byteen    <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req && legal) begin
                        func3_q          <= func3;
                        offset_q         <= address[1:0];
                        dcache_read      <= mem_read;
                        dcache_write     <= mem_write;
                        dcache_address   <= {address[31:2], 2'b00};
                        dcache_writedata <= st_data;
                        dcache_byteen    <= st_byteen;
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!dcache_busywait) begin
                        dcache_read  <= 1'b0;
                        dcache_write <= 1'b0;
                        if (dcache_read) begin
                            load_data <= ld_result;
                        end
                        state <= DONE;
                    end
                end
                // One non-stalled cycle lets the pipeline move past this instruction
                // before a held request could be seen again in IDLE.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_access_controller.sv
// Self-checking bench for data_access_controller: directed scenarios plus random
// load/store traffic compared against an arithmetic reference model.
module tb_data_access_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] load_data;
    logic        busy_wait;
    logic        access_fault;
    logic        dcache_read;
    logic        dcache_write;
    logic [31:0] dcache_address;
    logic [31:0] dcache_writedata;
    logic [3:0]  dcache_byteen;
    logic [31:0] dcache_readdata;
    logic        dcache_busywait;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_load = 32'h0;

    always #5 clock = ~clock;

    data_access_controller dut (
        .clock            (clock),
        .reset            (reset),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .func3            (func3),
        .address          (address),
        .write_data       (write_data),
        .load_data        (load_data),
        .busy_wait        (busy_wait),
        .access_fault     (access_fault),
        .dcache_read      (dcache_read),
        .dcache_write     (dcache_write),
        .dcache_address   (dcache_address),
        .dcache_writedata (dcache_writedata),
        .dcache_byteen    (dcache_byteen),
        .dcache_readdata  (dcache_readdata),
        .dcache_busywait  (dcache_busywait)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] a);
        if (rd == wr) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (wr && f3 > 3'd2) return 1'b0;
        return (a % access_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_byteen(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] mask;
        mask = 4'((32'd1 << access_size(f3)) - 32'd1);
        return 4'(mask << a[1:0]);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (access_size(f3))
            1:       return (wd & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (wd & 32'h0000_FFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        logic [31:0] mask;
        int          size;
        size = access_size(f3);
        v    = rdata >> (8 * a[1:0]);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        v    = v & mask;
        if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
        return v;
    endfunction

    // One pipeline instruction; n is the number of ACCESS cycles the cache takes.
    task automatic do_txn(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdata, input int n);
        bit legal;
        int stall;
        legal = model_legal(rd, wr, f3, a);
        @(negedge clock);
        mem_read        = rd;
        mem_write       = wr;
        func3           = f3;
        address         = a;
        write_data      = wd;
        dcache_busywait = 1'b1;
        dcache_readdata = $urandom;
        #1;
        check("access_fault", 32'(access_fault), 32'(!legal));
        if (!legal) begin
            check("stall_on_fault", 32'(busy_wait), 32'h0);
            @(negedge clock);
            #1;
            check("fault_no_read", 32'(dcache_read), 32'h0);
            check("fault_no_write", 32'(dcache_write), 32'h0);
            check("fault_load_kept", load_data, exp_load);
        end else begin
            stall = 0;
            while (busy_wait && stall < 64) begin
                stall++;
                if (stall >= 2) begin
                    if (stall == 2) begin
                        check("dc_read", 32'(dcache_read), 32'(rd));
                        check("dc_write", 32'(dcache_write), 32'(wr));
                        check("dc_address", dcache_address, a & 32'hFFFF_FFFC);
                        check("dc_byteen", 32'(dcache_byteen), wr ? 32'(model_byteen(f3, a)) : 32'h0);
                        if (wr) check("dc_writedata", dcache_writedata, model_wdata(f3, wd));
                    end
                    dcache_busywait = (stall - 1 < n);
                    dcache_readdata = dcache_busywait ? $urandom : rdata;
                end
                @(negedge clock);
                #1;
            end
            check("stall_cycles", 32'(stall), 32'(n + 1));
            check("done_read_dropped", 32'(dcache_read), 32'h0);
            check("done_write_dropped", 32'(dcache_write), 32'h0);
            if (rd) exp_load = model_load(f3, a, rdata);
            check("load_data", load_data, exp_load);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        func3           = 3'b000;
        address         = 32'h0;
        write_data      = 32'h0;
        dcache_readdata = 32'h0;
        dcache_busywait = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_load_data", load_data, 32'h0);
        check("rst_read", 32'(dcache_read), 32'h0);
        check("rst_write", 32'(dcache_write), 32'h0);
        check("rst_address", dcache_address, 32'h0);
        check("rst_writedata", dcache_writedata, 32'h0);
        check("rst_byteen", 32'(dcache_byteen), 32'h0);
        check("rst_busy_wait", 32'(busy_wait), 32'h0);
        check("rst_fault", 32'(access_fault), 32'h0);

        do_txn(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        do_txn(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 3);
        do_txn(0, 1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 2);
        do_txn(1, 0, 3'b010, 32'h0000_4001, 32'h0, 32'h0, 1);
        do_txn(1, 0, 3'b001, 32'h0000_4003, 32'h0, 32'h0, 1);
        do_txn(1, 1, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 1);

        @(negedge clock);
        mem_read        = 1'b1;
        func3           = 3'b010;
        address         = 32'h0000_5000;
        dcache_busywait = 1'b1;
        @(negedge clock);
        #1;
        check("pre_rst_read", 32'(dcache_read), 32'h1);
        reset    = 1'b1;
        mem_read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        exp_load = 32'h0;
        check("mid_rst_read", 32'(dcache_read), 32'h0);
        check("mid_rst_busy", 32'(busy_wait), 32'h0);
        check("mid_rst_load", load_data, 32'h0);
        do_txn(0, 1, 3'b010, 32'h0000_6004, 32'hCAFE_F00D, 32'h0, 1);

        for (int i = 0; i < 60; i++) begin
            int          sel;
            bit          rd;
            bit          wr;
            logic [2:0]  f3;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            rd  = (sel < 5) || (sel == 9);
            wr  = (sel >= 5);
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            do_txn(rd, wr, f3, a, $urandom, $urandom, int'($urandom_range(1, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
